// File: rtl/sigmoid_lut_arbiter_if.sv
// Request/response bundle between the activation-stage clients and sigmoid_lut_arbiter.
// Signal names keep the arbiter's port names so waveforms line up with the block's port list.
interface sigmoid_lut_arbiter_if #(
    parameter int width_p   = 8,
    parameter int num_req_p = 2
);
    logic [num_req_p-1:0]         req_valid_i;
    logic [num_req_p*width_p-1:0] req_x_i;
    logic [num_req_p-1:0]         req_ready_o;
    logic [num_req_p-1:0]         resp_valid_o;
    logic [num_req_p*width_p-1:0] resp_f_o;
    logic [num_req_p-1:0]         resp_ready_i;

    modport master (
        output req_valid_i,
        output req_x_i,
        output resp_ready_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_f_o
    );

    modport slave (
        input  req_valid_i,
        input  req_x_i,
        input  resp_ready_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_f_o
    );
endinterface

// File: rtl/sigmoid_lut_arbiter.sv
// Round-robin sharing of one async-read sigmoid table among num_req_p requesters, 1-cycle latency.
// Define SIGMOID_ARB_WR_EN to add a table-update port that takes absolute priority over reads.
module sigmoid_lut_arbiter #(
    parameter int width_p   = 8,
    parameter int num_req_p = 2,
    parameter int stall_w_p = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    sigmoid_lut_arbiter_if.slave req_if,
    output logic [width_p-1:0]   ram_rd_addr_o,
    input  logic [width_p-1:0]   ram_rd_data_i,
`ifdef SIGMOID_ARB_WR_EN
    input  logic                 cfg_wr_valid_i,
    input  logic [width_p-1:0]   cfg_wr_addr_i,
    input  logic [width_p-1:0]   cfg_wr_data_i,
    output logic                 cfg_wr_ready_o,
    output logic                 ram_wr_valid_o,
    output logic [width_p-1:0]   ram_wr_addr_o,
    output logic [width_p-1:0]   ram_wr_data_o,
`endif
    output logic [stall_w_p-1:0] stall_count_o
);

    localparam int ptr_w_lp = (num_req_p > 2) ? $clog2(num_req_p) : 1;
    localparam logic [ptr_w_lp:0]    num_lp  = (ptr_w_lp+1)'(num_req_p);
    localparam logic [ptr_w_lp-1:0]  last_lp = ptr_w_lp'(num_req_p - 1);
    localparam logic [num_req_p-1:0] one_lp  = num_req_p'(1);
    localparam logic [width_p-1:0]   half_lp = {1'b1, {(width_p-1){1'b0}}};

    logic [ptr_w_lp-1:0]          rr_ptr_r;
    logic [stall_w_p-1:0]         stall_r;
    logic [num_req_p-1:0]         resp_valid_r;
    logic [num_req_p*width_p-1:0] resp_f_r;

    logic                         wr_active;
    logic [num_req_p-1:0]         eligible;
    logic [2*num_req_p-1:0]       elig_dbl;
    logic [num_req_p-1:0]         elig_rot;
    logic                         grant_v;
    logic [ptr_w_lp-1:0]          grant_off;
    logic [ptr_w_lp:0]            idx_sum;
    logic [ptr_w_lp-1:0]          grant_idx;
    logic [num_req_p-1:0]         grant;
    logic [num_req_p*width_p-1:0] req_x_sh;
    logic [width_p-1:0]           grant_x;
    logic                         lost;

`ifdef SIGMOID_ARB_WR_EN
    assign wr_active      = cfg_wr_valid_i & reset_ni;
    assign cfg_wr_ready_o = wr_active;
    assign ram_wr_valid_o = wr_active;
    assign ram_wr_addr_o  = cfg_wr_addr_i;
    assign ram_wr_data_o  = cfg_wr_data_i;
`else
    assign wr_active = 1'b0;
`endif

    // Rotate the eligible mask so the pointer sits at bit 0, take the first set bit,
    // then rotate the offset back into a requester index.
    always_comb begin
        eligible  = req_if.req_valid_i & (~resp_valid_r | req_if.resp_ready_i);
        elig_dbl  = {eligible, eligible} >> rr_ptr_r;
        elig_rot  = elig_dbl[num_req_p-1:0];
        grant_v   = 1'b0;
        grant_off = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!grant_v && elig_rot[i]) begin
                grant_v   = 1'b1;
                grant_off = i[ptr_w_lp-1:0];
            end
        end
        if (wr_active || !reset_ni) begin
            grant_v = 1'b0;
        end
        idx_sum = {1'b0, rr_ptr_r} + {1'b0, grant_off};
        if (idx_sum >= num_lp) begin
            idx_sum = idx_sum - num_lp;
        end
        grant_idx = idx_sum[ptr_w_lp-1:0];
        grant     = grant_v ? (one_lp << grant_idx) : '0;
        req_x_sh  = req_if.req_x_i >> (int'(grant_idx) * width_p);
        grant_x   = req_x_sh[width_p-1:0];
        lost      = |(eligible & ~grant);
    end

    assign ram_rd_addr_o       = grant_v ? (grant_x + half_lp) : '0;
    assign req_if.req_ready_o  = grant;
    assign req_if.resp_valid_o = resp_valid_r;
    assign req_if.resp_f_o     = resp_f_r;
    assign stall_count_o       = stall_r;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_r <= '0;
            stall_r  <= '0;
        end else begin
            if (grant_v) begin
                rr_ptr_r <= (grant_idx == last_lp) ? '0 : grant_idx + ptr_w_lp'(1);
            end
            if (lost && (stall_r != {stall_w_p{1'b1}})) begin
                stall_r <= stall_r + stall_w_p'(1);
            end
        end
    end

    // A grant reloads the slot even while it drains; data is left untouched when a slot empties.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            resp_valid_r <= '0;
            resp_f_r     <= '0;
        end else begin
            for (int k = 0; k < num_req_p; k++) begin
                if (grant[k]) begin
                    resp_valid_r[k]                 <= 1'b1;
                    resp_f_r[k*width_p +: width_p] <= ram_rd_data_i;
                end else if (req_if.resp_ready_i[k]) begin
                    resp_valid_r[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_lut_arbiter.sv
// Scoreboard bench for sigmoid_lut_arbiter: a round-robin reference model predicts grants and results,
// a monitor checks responses as consumers take them. SIGMOID_ARB_WR_EN adds a table-write scenario.
module tb_sigmoid_lut_arbiter;

    localparam int W  = 8;
    localparam int N  = 2;
    localparam int SW = 16;

    typedef struct {
        int           k;
        logic [W-1:0] f;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  ram_rd_addr;
    logic [W-1:0]  ram_rd_data;
    logic [SW-1:0] stall_count;
    logic [W-1:0]  tbl [256];

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    bit            in_rst = 1'b1;
    bit            acc [N];
    int            ptr_m = 0;
    int            stall_m = 0;

    always #5 clk = ~clk;

    sigmoid_lut_arbiter_if #(.width_p(W), .num_req_p(N)) bus ();

    assign ram_rd_data = tbl[ram_rd_addr];

`ifdef SIGMOID_ARB_WR_EN
    logic         cfg_wr_valid = 1'b0;
    logic [W-1:0] cfg_wr_addr = '0;
    logic [W-1:0] cfg_wr_data = '0;
    logic         cfg_wr_ready;
    logic         ram_wr_valid;
    logic [W-1:0] ram_wr_addr;
    logic [W-1:0] ram_wr_data;

    always @(posedge clk) begin
        if (ram_wr_valid) tbl[ram_wr_addr] = ram_wr_data;
    end
`endif

    sigmoid_lut_arbiter #(.width_p(W), .num_req_p(N), .stall_w_p(SW)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .req_if        (bus.slave),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data),
`ifdef SIGMOID_ARB_WR_EN
        .cfg_wr_valid_i(cfg_wr_valid),
        .cfg_wr_addr_i (cfg_wr_addr),
        .cfg_wr_data_i (cfg_wr_data),
        .cfg_wr_ready_o(cfg_wr_ready),
        .ram_wr_valid_o(ram_wr_valid),
        .ram_wr_addr_o (ram_wr_addr),
        .ram_wr_data_o (ram_wr_data),
`endif
        .stall_count_o (stall_count)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic int pending(input int k);
        int n = 0;
        foreach (sb[i]) if (sb[i].k == k) n++;
        return n;
    endfunction

    // Requests not yet accepted by the model keep their valid and x; others take the new values.
    task automatic apply_stimulus(input logic [N-1:0] want_valid, input logic [N*W-1:0] xs,
                                  input logic [N-1:0] ready);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (!(bus.req_valid_i[k] && !acc[k])) begin
                bus.req_valid_i[k]   = want_valid[k];
                bus.req_x_i[k*W +: W] = xs[k*W +: W];
            end
        end
        bus.resp_ready_i = ready;
    endtask

    // Monitor: pops the scoreboard whenever a consumer takes a response.
    always @(negedge clk) begin
        if (!in_rst) begin
            for (int k = 0; k < N; k++) begin
                check_output($sformatf("resp_valid[%0d]", k), 32'(bus.resp_valid_o[k]),
                             32'(pending(k) != 0));
                if (bus.resp_valid_o[k] && bus.resp_ready_i[k]) begin
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].k == k) begin
                            check_output($sformatf("resp_f[%0d]", k), 32'(bus.resp_f_o[k*W +: W]),
                                         32'(sb[i].f));
                            sb.delete(i);
                            break;
                        end
                    end
                end
            end
        end
    end

    // Reference model: round-robin over eligible requesters, address = signed x + 128.
    always @(negedge clk) begin
        #1;
        if (!in_rst) begin
            int           g;
            int           n_elig;
            bit           wr;
            bit           elig [N];
            logic [W-1:0] xg;
            logic [W-1:0] ea;
            logic [N-1:0] er;
            g      = -1;
            n_elig = 0;
            wr     = 1'b0;
`ifdef SIGMOID_ARB_WR_EN
            wr = cfg_wr_valid;
            if (wr) begin
                check_output("cfg_wr_ready", 32'(cfg_wr_ready), 32'd1);
                check_output("ram_wr_addr", 32'(ram_wr_addr), 32'(cfg_wr_addr));
                check_output("ram_wr_data", 32'(ram_wr_data), 32'(cfg_wr_data));
            end
`endif
            for (int k = 0; k < N; k++) begin
                elig[k] = bus.req_valid_i[k] && (pending(k) == 0 || bus.resp_ready_i[k]);
                if (elig[k]) n_elig++;
                acc[k] = 1'b0;
            end
            if (!wr) begin
                for (int i = 0; i < N; i++) begin
                    int c;
                    c = (ptr_m + i) % N;
                    if (g < 0 && elig[c]) g = c;
                end
            end
            er = '0;
            ea = '0;
            if (g >= 0) begin
                xg    = bus.req_x_i[g*W +: W];
                ea    = W'(int'($signed(xg)) + 128);
                er[g] = 1'b1;
            end
            check_output("req_ready", 32'(bus.req_ready_o), 32'(er));
            check_output("ram_rd_addr", 32'(ram_rd_addr), 32'(ea));
            check_output("stall_count", 32'(stall_count), 32'(stall_m));
            if (n_elig > ((g >= 0) ? 1 : 0) && stall_m < (2**SW - 1)) stall_m++;
            if (g >= 0) begin
                sb.push_back('{g, tbl[ea]});
                ptr_m  = (g + 1) % N;
                acc[g] = 1'b1;
            end
        end
    end

    task automatic model_reset();
        sb.delete();
        ptr_m   = 0;
        stall_m = 0;
        for (int k = 0; k < N; k++) acc[k] = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) tbl[a] = W'($urandom);
        bus.req_valid_i  = '0;
        bus.req_x_i      = '0;
        bus.resp_ready_i = '0;

        // Power-on reset with requests pending: nothing may be granted.
        #12;
        bus.req_valid_i = '1;
        #1;
        check_output("reset req_ready", 32'(bus.req_ready_o), 32'd0);
        check_output("reset resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check_output("reset resp_f", 32'(bus.resp_f_o), 32'd0);
        check_output("reset stall", 32'(stall_count), 32'd0);
        check_output("reset rd_addr", 32'(ram_rd_addr), 32'd0);
        bus.req_valid_i = '0;
        #9;
        reset_n = 1'b1;
        in_rst  = 1'b0;

        // Single request and address wrap corners.
        apply_stimulus(2'b01, 16'h0000, 2'b11);
        apply_stimulus(2'b01, 16'h007F, 2'b11);
        apply_stimulus(2'b01, 16'h0080, 2'b11);
        apply_stimulus(2'b01, 16'h00FF, 2'b11);
        apply_stimulus(2'b00, 16'h0000, 2'b11);
        apply_stimulus(2'b00, 16'h0000, 2'b11);

        // Contention: grants must alternate and stalls accumulate.
        for (int c = 0; c < 8; c++) apply_stimulus(2'b11, 16'($urandom), 2'b11);

        // Backpressure on requester 0, then release it.
        for (int c = 0; c < 5; c++) apply_stimulus(2'b11, 16'($urandom), 2'b10);
        for (int c = 0; c < 3; c++) apply_stimulus(2'b11, 16'($urandom), 2'b11);
        for (int c = 0; c < 3; c++) apply_stimulus(2'b11, 16'($urandom), 2'b10);

        // Asynchronous reset between edges with slots full.
        @(posedge clk);
        #3;
        in_rst  = 1'b1;
        reset_n = 1'b0;
        #1;
        check_output("midreset resp_valid", 32'(bus.resp_valid_o), 32'd0);
        check_output("midreset stall", 32'(stall_count), 32'd0);
        check_output("midreset req_ready", 32'(bus.req_ready_o), 32'd0);
        model_reset();
        bus.req_valid_i  = '0;
        bus.resp_ready_i = '0;
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        in_rst  = 1'b0;
        for (int c = 0; c < 4; c++) apply_stimulus(2'b11, 16'($urandom), 2'b11);

`ifdef SIGMOID_ARB_WR_EN
        // Table write blocks the read, then the read returns the new entry.
        apply_stimulus(2'b00, 16'h0000, 2'b11);
        apply_stimulus(2'b00, 16'h0000, 2'b11);
        @(posedge clk);
        #1;
        cfg_wr_valid    = 1'b1;
        cfg_wr_addr     = 8'h80;
        cfg_wr_data     = 8'h55;
        bus.req_valid_i = 2'b01;
        bus.req_x_i     = 16'h0000;
        @(posedge clk);
        #1;
        cfg_wr_valid = 1'b0;
        @(negedge clk);
        #2;
        check_output("write-then-read table", 32'(tbl[8'h80]), 32'h55);
        apply_stimulus(2'b00, 16'h0000, 2'b11);
        apply_stimulus(2'b00, 16'h0000, 2'b11);
`endif

        // Randomized traffic.
        for (int c = 0; c < 300; c++) apply_stimulus(N'($urandom), 16'($urandom), N'($urandom));

        // Drain and confirm every expected response was delivered.
        for (int c = 0; c < 4; c++) apply_stimulus(2'b00, 16'h0000, 2'b11);
        @(negedge clk);
        #2;
        check_output("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
